branch_predictor_bht: RTL and testbench

BRANCH_PREDICTOR_BHT -- requirements
Module: branch_predictor_bht

---
 rtl/branch_predictor_bht.sv | 168 ++++++++++++++++
 tb/tb_branch_predictor_bht.sv | 211 +++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// branch_predictor_bht
//
// Direct-mapped branch history table. Each entry holds a 2-bit saturating
// counter, a valid bit, a PC tag and a taken-target address. The fetch stage
// looks up the table combinationally. The execute stage trains it with
// resolved branches.
//
// Parameters
//   INDEX_BITS  log2 of the number of table entries (default 16 entries)
//   B_TYPE      branch major opcode, compared against inst[6:2]
//
// Ports
//   clk, rst          clock; asynchronous active-high reset
//   pcF, instF        fetch-stage PC and instruction (lookup side)
//   upd_valid         execute stage presents a resolved branch this cycle
//   upd_pc            PC of the resolved branch
//   upd_taken         actual outcome of the resolved branch
//   upd_target        actual taken target of the resolved branch
//   predict_fail      mispredict flush; suppresses any taken prediction
//   pred_taken        fetch-stage taken prediction
//   pred_target       predicted next PC (stored target, or pcF+4)
//   pcmux_sel_F       PC-mux select (same as pred_taken)
//
// Optional feature (macro BP_STATS_EN)
//   branch_cnt        number of edges with upd_valid=1 (wraps)
//   mispredict_cnt    number of edges with predict_fail=1 (wraps)
// -----------------------------------------------------------------------------
module branch_predictor_bht #(
    parameter int         INDEX_BITS = 4,
    parameter logic [4:0] B_TYPE     = 5'b11000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] pcF,
    input  logic [31:0] instF,
    input  logic        upd_valid,
    input  logic [31:0] upd_pc,
    input  logic        upd_taken,
    input  logic [31:0] upd_target,
    input  logic        predict_fail,
    output logic        pred_taken,
    output logic [31:0] pred_target,
    output logic        pcmux_sel_F
`ifdef BP_STATS_EN
    ,
    output logic [31:0] branch_cnt,
    output logic [31:0] mispredict_cnt
`endif
);

    localparam int ENTRIES = 1 << INDEX_BITS;
    localparam int TAG_W   = 32 - INDEX_BITS - 2;

    logic [1:0]       ctr_q    [ENTRIES];
    logic [1:0]       ctr_d    [ENTRIES];
    logic             valid_q  [ENTRIES];
    logic             valid_d  [ENTRIES];
    logic [TAG_W-1:0] tag_q    [ENTRIES];
    logic [TAG_W-1:0] tag_d    [ENTRIES];
    logic [31:0]      target_q [ENTRIES];
    logic [31:0]      target_d [ENTRIES];

    logic [INDEX_BITS-1:0] lkp_idx;
    logic [TAG_W-1:0]      lkp_tag;
    logic [INDEX_BITS-1:0] upd_idx;
    logic [TAG_W-1:0]      upd_tag;
    logic                  lkp_hit;
    logic                  is_branch;

    assign lkp_idx = pcF[INDEX_BITS+1:2];
    assign lkp_tag = pcF[31:INDEX_BITS+2];
    assign upd_idx = upd_pc[INDEX_BITS+1:2];
    assign upd_tag = upd_pc[31:INDEX_BITS+2];

    // Byte-offset bits and non-opcode instruction bits play no role in the
    // lookup; fold them into a sink so their disuse is explicit.
    logic unused_bits;
    assign unused_bits = ^{pcF[1:0], upd_pc[1:0], instF[31:7], instF[1:0]};

    // ---------------------------------------------------------------- lookup
    // The lookup reads the registered table, so an update landing on the
    // same index in the same cycle is only seen from the next cycle on.
    assign is_branch = (instF[6:2] == B_TYPE);
    assign lkp_hit   = valid_q[lkp_idx] && (tag_q[lkp_idx] == lkp_tag);

    always_comb begin
        pred_taken  = 1'b0;
        pred_target = pcF + 32'd4;
        if (!rst && is_branch && lkp_hit && ctr_q[lkp_idx][1] && !predict_fail) begin
            pred_taken  = 1'b1;
            pred_target = target_q[lkp_idx];
        end
    end

    assign pcmux_sel_F = pred_taken;

    // ---------------------------------------------------------------- update
    always_comb begin
        ctr_d    = ctr_q;
        valid_d  = valid_q;
        tag_d    = tag_q;
        target_d = target_q;
        if (upd_valid) begin
            if (upd_taken) begin
                // A taken branch claims the entry. If another branch owned
                // it, start fresh at weakly taken instead of inheriting the
                // previous owner's history.
                if (tag_q[upd_idx] != upd_tag) begin
                    ctr_d[upd_idx] = 2'd2;
                end else if (ctr_q[upd_idx] != 2'd3) begin
                    ctr_d[upd_idx] = ctr_q[upd_idx] + 2'd1;
                end
                valid_d[upd_idx]  = 1'b1;
                tag_d[upd_idx]    = upd_tag;
                target_d[upd_idx] = upd_target;
            end else if (ctr_q[upd_idx] != 2'd0) begin
                // Not-taken only trains the counter; tag and target stay.
                ctr_d[upd_idx] = ctr_q[upd_idx] - 2'd1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < ENTRIES; gi++) begin : g_entry
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    ctr_q[gi]    <= 2'd1;
                    valid_q[gi]  <= 1'b0;
                    tag_q[gi]    <= '0;
                    target_q[gi] <= '0;
                end else begin
                    ctr_q[gi]    <= ctr_d[gi];
                    valid_q[gi]  <= valid_d[gi];
                    tag_q[gi]    <= tag_d[gi];
                    target_q[gi] <= target_d[gi];
                end
            end
        end
    endgenerate

`ifdef BP_STATS_EN
    // ------------------------------------------------------------ statistics
    logic [31:0] branch_cnt_q;
    logic [31:0] branch_cnt_d;
    logic [31:0] mispredict_cnt_q;
    logic [31:0] mispredict_cnt_d;

    always_comb begin
        branch_cnt_d     = branch_cnt_q + {31'd0, upd_valid};
        mispredict_cnt_d = mispredict_cnt_q + {31'd0, predict_fail};
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            branch_cnt_q     <= '0;
            mispredict_cnt_q <= '0;
        end else begin
            branch_cnt_q     <= branch_cnt_d;
            mispredict_cnt_q <= mispredict_cnt_d;
        end
    end

    assign branch_cnt     = branch_cnt_q;
    assign mispredict_cnt = mispredict_cnt_q;
`endif

endmodule

// File: tb/tb_branch_predictor_bht.sv
// -----------------------------------------------------------------------------
// tb_branch_predictor_bht
//
// Directed test of branch_predictor_bht: reset behaviour, allocation,
// counter saturation, tag conflicts, read-before-write, pcF+4 wrap, no
// change when idle and, when BP_STATS_EN is defined, the statistic counters.
// -----------------------------------------------------------------------------
module tb_branch_predictor_bht;

    localparam logic [31:0] BR_INST  = 32'h0000_0063;  // B-type opcode
    localparam logic [31:0] ALU_INST = 32'h0000_0013;  // not a branch

    logic        clk;
    logic        rst;
    logic [31:0] pcF;
    logic [31:0] instF;
    logic        upd_valid;
    logic [31:0] upd_pc;
    logic        upd_taken;
    logic [31:0] upd_target;
    logic        predict_fail;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        pcmux_sel_F;
`ifdef BP_STATS_EN
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;
`endif

    int chk_cnt;
    int pass_cnt;

    branch_predictor_bht dut (
        .clk         (clk),
        .rst         (rst),
        .pcF         (pcF),
        .instF       (instF),
        .upd_valid   (upd_valid),
        .upd_pc      (upd_pc),
        .upd_taken   (upd_taken),
        .upd_target  (upd_target),
        .predict_fail(predict_fail),
        .pred_taken  (pred_taken),
        .pred_target (pred_target),
        .pcmux_sel_F (pcmux_sel_F)
`ifdef BP_STATS_EN
        ,
        .branch_cnt    (branch_cnt),
        .mispredict_cnt(mispredict_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        chk_cnt++;
        if (got === exp) begin
            pass_cnt++;
            $display("ok   %-24s got=%08h", tag, got);
        end else begin
            $display("FAIL %-24s got=%08h expected=%08h", tag, got, exp);
        end
    endtask

    // Combinational lookup; caller is away from the clock edge.
    task automatic lookup(input string tag, input logic [31:0] pc,
                          input logic exp_taken, input logic [31:0] exp_target);
        pcF = pc;
        #1;
        check({tag, ".taken"},  {31'd0, pred_taken},  {31'd0, exp_taken});
        check({tag, ".target"}, pred_target,          exp_target);
        check({tag, ".pcmux"},  {31'd0, pcmux_sel_F}, {31'd0, exp_taken});
    endtask

    task automatic update(input logic [31:0] pc, input logic taken, input logic [31:0] tgt);
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = pc;
        upd_taken  = taken;
        upd_target = tgt;
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
    endtask

    task automatic fail_pulse();
        @(negedge clk);
        predict_fail = 1'b1;
        @(posedge clk);
        #1;
        predict_fail = 1'b0;
    endtask

    initial begin
        chk_cnt      = 0;
        pass_cnt     = 0;
        rst          = 1'b1;
        pcF          = 32'h100;
        instF        = BR_INST;
        upd_valid    = 1'b0;
        upd_pc       = 32'h0;
        upd_taken    = 1'b0;
        upd_target   = 32'h0;
        predict_fail = 1'b0;

        // Outputs held while in reset.
        repeat (2) @(negedge clk);
        lookup("in_reset", 32'h100, 1'b0, 32'h104);
        @(negedge clk);
        rst = 1'b0;

        // Cold lookup after reset.
        lookup("cold", 32'h100, 1'b0, 32'h104);

        // Reset counter is 1: one not-taken (1->0) then taken (same tag 0,
        // 0->1) leaves the entry valid but not-taken.
        update(32'h4, 1'b0, 32'h0);
        update(32'h4, 1'b1, 32'h40);
        lookup("rst_ctr_is_1", 32'h4, 1'b0, 32'h8);

        // Allocation: counter 2, target 0x80.
        update(32'h100, 1'b1, 32'h80);
        lookup("alloc", 32'h100, 1'b1, 32'h80);

        // Non-branch opcode and predict_fail suppress the prediction.
        instF = ALU_INST;
        lookup("not_branch", 32'h100, 1'b0, 32'h104);
        instF = BR_INST;
        predict_fail = 1'b1;
        lookup("pfail", 32'h100, 1'b0, 32'h104);
        predict_fail = 1'b0;

        // Idle cycles with garbage update fields change nothing.
        upd_pc    = 32'h100;
        upd_taken = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        lookup("idle", 32'h100, 1'b1, 32'h80);

        // Saturate low: 2->1->0->0->0, then taken 0->1 (still not taken),
        // then taken 1->2 (taken again).
        repeat (4) update(32'h100, 1'b0, 32'h0);
        lookup("sat0", 32'h100, 1'b0, 32'h104);
        update(32'h100, 1'b1, 32'h80);
        lookup("sat0_plus1", 32'h100, 1'b0, 32'h104);
        update(32'h100, 1'b1, 32'h80);
        lookup("ctr2", 32'h100, 1'b1, 32'h80);

        // Saturate high: 2->3->3, one not-taken gives 2 (still taken).
        repeat (2) update(32'h100, 1'b1, 32'h80);
        update(32'h100, 1'b0, 32'h0);
        lookup("sat3_minus1", 32'h100, 1'b1, 32'h80);

        // Same index, different tag.
        lookup("conflict_miss", 32'h140, 1'b0, 32'h144);
        update(32'h140, 1'b1, 32'h200);
        lookup("realloc_new", 32'h140, 1'b1, 32'h200);
        lookup("realloc_old", 32'h100, 1'b0, 32'h104);

        // Not-taken with a tag mismatch keeps tag/target: counter 2->1.
        update(32'h100, 1'b0, 32'h0);
        update(32'h140, 1'b1, 32'h200);
        lookup("nt_mismatch", 32'h140, 1'b1, 32'h200);

        // Read-before-write: counter at 0x140 is 2; a not-taken update in the
        // same cycle as the lookup leaves this cycle's prediction taken.
        @(negedge clk);
        upd_valid  = 1'b1;
        upd_pc     = 32'h140;
        upd_taken  = 1'b0;
        lookup("rbw_before", 32'h140, 1'b1, 32'h200);
        @(posedge clk);
        #1;
        upd_valid = 1'b0;
        lookup("rbw_after", 32'h140, 1'b0, 32'h144);

        // pcF+4 wraps modulo 2^32.
        lookup("wrap", 32'hFFFF_FFFC, 1'b0, 32'h0);

        // Mid-run reset clears the table and statistics.
        update(32'h140, 1'b1, 32'h200);
        lookup("pre_rst", 32'h140, 1'b1, 32'h200);
        @(negedge clk);
        rst = 1'b1;
        #1;
        lookup("mid_rst", 32'h140, 1'b0, 32'h144);
`ifdef BP_STATS_EN
        check("rst.branch_cnt", branch_cnt, 32'd0);
        check("rst.mispredict_cnt", mispredict_cnt, 32'd0);
`endif
        @(negedge clk);
        rst = 1'b0;
        lookup("post_rst", 32'h140, 1'b0, 32'h144);

        // Three updates and one flush pulse: alloc 2, 3, then 2.
        update(32'h100, 1'b1, 32'h80);
        update(32'h100, 1'b1, 32'h80);
        update(32'h100, 1'b0, 32'h0);
        fail_pulse();
        lookup("post_rst_train", 32'h100, 1'b1, 32'h80);
`ifdef BP_STATS_EN
        check("branch_cnt", branch_cnt, 32'd3);
        check("mispredict_cnt", mispredict_cnt, 32'd1);
`endif

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
